// File: rtl/rca_pipe_result_buf.sv
// ---------------------------------------------------------------------------
// rca_pipe_result_buf
//
// Downstream companion of a free-running pipelined ripple-carry adder. The
// adder has no valid and no stall, so this block does the bookkeeping for it:
//   - A valid delay line follows each issued operand pair through the adder
//     pipeline. It marks the cycle in which that pair's {cout,sum} appears on
//     adder_res.
//   - Marked results are written into a first-word-fall-through FIFO.
//   - Upstream issue is throttled by a credit count, so every issued result
//     has a FIFO slot reserved before it emerges.
//
// Optional feature (compile-time macro RCA_RESBUF_STATS_EN):
//   adds res_cout_cnt, a saturating count of captured results with cout=1.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1 (issue = in_valid & in_ready, pop = out_valid & out_ready). A source
// holding valid=1 may not withdraw it. Neither ready depends combinationally
// on the valid it qualifies.
//
// Ports:
//   clk          in   1        rising-edge clock, shared with the adder
//   rst          in   1        synchronous, active-high reset
//   in_valid     in   1        upstream presents operands to the adder
//   in_ready     out  1        issue permitted
//   adder_res    in   WIDTH+1  adder output {cout,sum}
//   out_valid    out  1        FIFO head valid
//   out_ready    in   1        consumer accepts the head
//   out_sum      out  WIDTH    FIFO head sum (0 when out_valid=0)
//   out_cout     out  1        FIFO head carry (0 when out_valid=0)
//   res_cout_cnt out  16       only with RCA_RESBUF_STATS_EN
//
// Parameters: WIDTH (operand width), LATENCY (adder register stages, >= 2),
// DEPTH (FIFO entries, a power of 2, >= LATENCY).
// ---------------------------------------------------------------------------
module rca_pipe_result_buf #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 9,
  parameter int DEPTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   adder_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef RCA_RESBUF_STATS_EN
  ,
  output logic [15:0]      res_cout_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic               issue;
  logic               capture;
  logic               pop;
  logic [LATENCY-1:0] vdl;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      count;
  logic [CW:0]        occupancy;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [WIDTH:0]     mem [DEPTH];
  logic [WIDTH:0]     head;

  assign issue = in_valid & in_ready;
  assign pop   = out_valid & out_ready;

  // Issue in cycle t sets vdl[0] in cycle t+1, and vdl[k] in cycle t+1+k.
  // The last tap is therefore high in cycle t+LATENCY. That is the cycle in
  // which the adder presents that operand pair's result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vdl <= '0;
    end else begin
      vdl <= {vdl[LATENCY-2:0], issue};
    end
  end

  assign capture = vdl[LATENCY-1];

  // Credits count both results still in the adder and results in the FIFO.
  // Each issue therefore has a guaranteed slot when it is captured.
  assign occupancy = {1'b0, inflight} + {1'b0, count};
  assign in_ready  = (occupancy < (CW + 1)'(DEPTH)) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(capture);
      count    <= count + CW'(capture) - CW'(pop);
      if (capture) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: an entry becomes visible only after it is written.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= adder_res;
    end
  end

  assign head = mem[rd_ptr];

  // count is cleared only at the reset edge. The rst term keeps the outputs
  // quiet during the first reset cycle as well.
  assign out_valid = (count != '0) & ~rst;
  assign out_sum   = out_valid ? head[WIDTH-1:0] : '0;
  assign out_cout  = out_valid ? head[WIDTH] : 1'b0;

`ifdef RCA_RESBUF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      res_cout_cnt <= '0;
    end else if (capture && adder_res[WIDTH] && (res_cout_cnt != 16'hFFFF)) begin
      res_cout_cnt <= res_cout_cnt + 16'd1;
    end
  end
`endif

endmodule
